pixel_stream_tx: RTL
====================

// Module: pixel_stream_tx
// PURPOSE
//  Frame-buffer pixel source for the Harris pipeline. Holds one 8-bit greyscale
//  image in internal RAM, loaded through a write port. On a start pulse it
//  streams the image in raster order on pixel/pixel_valid, with programmable
//  horizontal blanking. It is the transmit end of the pixel/pixel_valid
//  interface consumed by harrisDetector (imageControl).
// PARAMETERS
//  IMG_W   64  pixels per line (>=2)
//  IMG_H   64  lines per frame (>=1)
//  AW      12  RAM address width; 2**AW >= IMG_W*IMG_H
//  HBLANK  4   idle cycles (pixel_valid=0) between lines; 0 = lines back-to-back
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   synchronous, active-high
//  wr_en        in   1   RAM write strobe
//  wr_addr      in   AW  RAM write address (raster index y*IMG_W+x)
//  wr_data      in   8   RAM write data
//  wr_err       out  1   1-cycle pulse: write dropped because busy=1
//  start        in   1   begin one frame (sampled only in IDLE)
//  busy         out  1   high from the cycle after start is accepted until done
//  pixel        out  8   pixel value; 0 whenever pixel_valid=0
//  pixel_valid  out  1   pixel qualifier
//  line_start   out  1   high with the first valid pixel of each line
//  frame_end    out  1   high with the last valid pixel of the frame
//  done         out  1   1-cycle pulse on the cycle after frame_end
// BEHAVIOUR
//  - Reset: every output is 0, FSM goes to IDLE, x/y counters are 0. RAM contents
//    are NOT cleared. Reset mid-frame aborts immediately; no done pulse.
//  - FSM: IDLE -start-> ACTIVE -(x==IMG_W-1, y<IMG_H-1, HBLANK>0)-> HBLANK
//    -(blank count==HBLANK-1)-> ACTIVE. If HBLANK==0, ACTIVE continues into the
//    next line. When the last pixel of the last line is issued, -> DRAIN -> IDLE.
//  - RAM read latency is 1 cycle. Read address = y*IMG_W+x, issued in ACTIVE.
//    pixel, pixel_valid, line_start and frame_end are registered and aligned
//    to the read data.
//  - Latency: start sampled at edge N => busy=1 after edge N; first pixel_valid
//    after edge N+2. Each line gives exactly IMG_W consecutive valid cycles,
//    followed by exactly HBLANK invalid cycles (none after the last line).
//  - Frame length: IMG_W*IMG_H valid cycles. done pulses the cycle after
//    frame_end. busy drops together with done. A new start is accepted the
//    cycle after done.
//  - start while busy: ignored, with no side effect.
//  - Writes: accepted when busy=0, in 1 cycle. wr_en while busy=1 is dropped
//    and pulses wr_err the next cycle. A write in the same cycle as an accepted
//    start completes, because busy is still 0 in that cycle.
//  - wr_addr >= IMG_W*IMG_H: the write is ignored, with no error.
//  - Counters: x wraps IMG_W-1 -> 0 and increments y. y never exceeds IMG_H-1.
// CONFIGURATION
//  TESTPAT_EN defined: adds input port testpat (1 bit), sampled together with
//    start and held for the whole frame. When it is 1, pixel = (x^y)&8'hFF and
//    the RAM is not read. Timing, flags and latency are identical to RAM mode.
//  TESTPAT_EN undefined: no testpat port; pixels always come from the RAM.
// TESTING
//  1. IMG_W=4, IMG_H=3, HBLANK=2. Load RAM[i]=i+10, pulse start -> pixels 10..21
//     in order, first valid 2 cycles after start, 2 idle cycles between lines,
//     line_start on 10/14/18, frame_end on 21, done one cycle later.
//  2. HBLANK=0, same image -> 12 consecutive valid cycles; line_start still
//     on 10/14/18.
//  3. Pulse start again during the frame, and wr_en (addr 0, data FF) during
//     the frame -> output stream is unchanged, one wr_err pulse, RAM[0] stays 10.
//  4. Assert reset after the 5th pixel -> all outputs 0 next cycle, no done.
//     A new start then yields the full 10..21 stream again (RAM preserved).
//  5. Write at addr 12 (out of range, 4x3) -> no wr_err; the next frame
//     is unchanged.
//  6. With TESTPAT_EN and testpat=1, 4x3 -> pixels x^y: 0,1,2,3, 1,0,3,2,
//     2,3,0,1. Flags identical to test 1.

Source files
------------

// File: rtl/pixel_stream_tx.sv
// rtl/pixel_stream_tx.sv - frame-buffer pixel source streaming one image in raster order with horizontal blanking
// Optional TESTPAT_EN adds a testpat input that replaces RAM data with an x^y pattern.
module pixel_stream_tx #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int AW     = 12,
   parameter int HBLANK = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   output logic          wr_err,
   input  logic          start,
`ifdef TESTPAT_EN
   input  logic          testpat,
`endif
   output logic          busy,
   output logic [7:0]    pixel,
   output logic          pixel_valid,
   output logic          line_start,
   output logic          frame_end,
   output logic          done
);

   localparam int XW   = (IMG_W > 1)  ? $clog2(IMG_W)  : 1;
   localparam int YW   = (IMG_H > 1)  ? $clog2(IMG_H)  : 1;
   localparam int BW   = (HBLANK > 1) ? $clog2(HBLANK) : 1;
   localparam int NPIX = IMG_W * IMG_H;

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_DRAIN} state_t;

   state_t        r_state;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic [BW-1:0] r_bcnt;
   logic [7:0]    r_mem [0:(2**AW)-1];
   logic [7:0]    r_rd_data;
   logic [7:0]    r_s1_tpix;
   logic          r_s1_valid;
   logic          r_s1_ls;
   logic          r_s1_fe;
   logic          r_busy;
   logic          r_wr_err;
   logic          r_done;
   logic [7:0]    r_pixel;
   logic          r_pixel_valid;
   logic          r_line_start;
   logic          r_frame_end;

   logic [AW-1:0] w_addr;
   logic          w_last_x;
   logic          w_last_y;
   logic          w_in_range;
   logic [7:0]    w_tp_pix;
   logic          w_tp;

   assign w_addr     = AW'(r_y) * AW'(IMG_W) + AW'(r_x);
   assign w_last_x   = (r_x == XW'(IMG_W - 1));
   assign w_last_y   = (r_y == YW'(IMG_H - 1));
   assign w_in_range = ({1'b0, wr_addr} < (AW + 1)'(NPIX));
   assign w_tp_pix   = 8'(32'(r_x) ^ 32'(r_y));

`ifdef TESTPAT_EN
   logic r_tp;
   assign w_tp = r_tp;
   always_ff @(posedge clk) begin
      if (reset)
         r_tp <= 1'b0;
      else if (r_state == S_IDLE && start)
         r_tp <= testpat;
   end
`else
   assign w_tp = 1'b0;
`endif

   // RAM has no reset so the image survives a mid-frame abort
   always_ff @(posedge clk) begin
      if (wr_en && !r_busy && w_in_range)
         r_mem[wr_addr] <= wr_data;
      if (r_state == S_ACTIVE && !w_tp)
         r_rd_data <= r_mem[w_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_x           <= '0;
         r_y           <= '0;
         r_bcnt        <= '0;
         r_s1_tpix     <= '0;
         r_s1_valid    <= 1'b0;
         r_s1_ls       <= 1'b0;
         r_s1_fe       <= 1'b0;
         r_busy        <= 1'b0;
         r_wr_err      <= 1'b0;
         r_done        <= 1'b0;
         r_pixel       <= '0;
         r_pixel_valid <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_end   <= 1'b0;
      end else begin
         r_wr_err      <= wr_en & r_busy;
         r_done        <= 1'b0;
         r_s1_valid    <= 1'b0;
         r_s1_ls       <= 1'b0;
         r_s1_fe       <= 1'b0;
         // second stage lines flags up with the 1-cycle RAM read data
         r_pixel_valid <= r_s1_valid;
         r_line_start  <= r_s1_ls;
         r_frame_end   <= r_s1_fe;
         r_pixel       <= !r_s1_valid ? 8'h00 : (w_tp ? r_s1_tpix : r_rd_data);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_ACTIVE;
                  r_busy  <= 1'b1;
                  r_x     <= '0;
                  r_y     <= '0;
               end
            end
            S_ACTIVE: begin
               r_s1_valid <= 1'b1;
               r_s1_ls    <= (r_x == '0);
               r_s1_fe    <= w_last_x && w_last_y;
               r_s1_tpix  <= w_tp_pix;
               if (w_last_x) begin
                  r_x <= '0;
                  if (w_last_y) begin
                     r_state <= S_DRAIN;
                  end else begin
                     r_y <= r_y + 1'b1;
                     if (HBLANK > 0) begin
                        r_state <= S_HBLANK;
                        r_bcnt  <= '0;
                     end
                  end
               end else begin
                  r_x <= r_x + 1'b1;
               end
            end
            S_HBLANK: begin
               if (r_bcnt == BW'(HBLANK - 1))
                  r_state <= S_ACTIVE;
               else
                  r_bcnt <= r_bcnt + 1'b1;
            end
            S_DRAIN: begin
               // wait for frame_end to leave the pipeline, then finish
               if (r_frame_end) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign wr_err      = r_wr_err;
   assign busy        = r_busy;
   assign done        = r_done;
   assign pixel       = r_pixel;
   assign pixel_valid = r_pixel_valid;
   assign line_start  = r_line_start;
   assign frame_end   = r_frame_end;

endmodule
